// File: rtl/srl_delay_ctrl_pkg.sv
// Shared constants and state encoding for the SRL16E delay controller.
// Imported by the controller and by any block that decodes its state.
package srl_delay_ctrl_pkg;

  localparam int SRL_DEPTH = 16;

  typedef enum logic {
    FLUSH = 1'b0,
    RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/srl_delay_ctrl.sv
// Tap/enable controller for an external SRL16E parallel shifter bank.
// Flushes the shifter after every delay change, then flags valid once filled.
module srl_delay_ctrl
  import srl_delay_ctrl_pkg::*;
#(
  parameter int         WIDTH      = 19,
  parameter logic [3:0] DELAY_INIT = 4'd0,
  parameter int         FLUSH_LEN  = SRL_DEPTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             delay_wr,
  input  logic [3:0]       delay_in,
  input  logic             hold,
  input  logic [WIDTH-1:0] d_in,
  input  logic [WIDTH-1:0] srl_q,
  output logic             srl_ce,
  output logic [3:0]       srl_adr,
  output logic [WIDTH-1:0] srl_d,
  output logic [WIDTH-1:0] q_out,
  output logic             q_valid,
  output logic             busy,
  output logic [3:0]       delay_cur
);

  localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_LEN - 1);

  state_t     state;
  logic [3:0] adr_r;
  logic [3:0] flush_cnt;
  logic [4:0] fill_cnt;
  logic [4:0] fill_tgt;
  logic       filled;

  assign fill_tgt = {1'b0, adr_r} + 5'd1;
  assign filled   = (state == RUN) && (fill_cnt == fill_tgt);

  assign srl_ce    = !hold;
  assign srl_adr   = adr_r;
  assign delay_cur = adr_r;
  assign srl_d     = (state == RUN) ? d_in : '0;
  assign q_valid   = filled && !hold;
  assign q_out     = q_valid ? srl_q : '0;
  assign busy      = !filled;

  // Flush always covers all taps, so stale data beyond the new tap is cleared too
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= FLUSH;
      adr_r     <= DELAY_INIT;
      flush_cnt <= '0;
      fill_cnt  <= '0;
    end else if (delay_wr) begin
      state     <= FLUSH;
      adr_r     <= delay_in;
      flush_cnt <= '0;
      fill_cnt  <= '0;
    end else if (!hold) begin
      unique case (state)
        FLUSH: begin
          flush_cnt <= flush_cnt + 4'd1;
          if (flush_cnt == FLUSH_LAST) begin
            state    <= RUN;
            fill_cnt <= '0;
          end
        end
        RUN: begin
          if (fill_cnt != fill_tgt)
            fill_cnt <= fill_cnt + 5'd1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_srl_delay_ctrl.sv
// Bench for srl_delay_ctrl with a behavioural SRL16E bank beside it.
// Reference model tracks enabled clocks since restart and the shifted history.
module tb_srl_delay_ctrl;

  localparam int W = 19;
  localparam logic [3:0] DINIT = 4'd3;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         delay_wr = 1'b0;
  logic [3:0]   delay_in = '0;
  logic         hold = 1'b0;
  logic [W-1:0] d_in = '0;
  logic [W-1:0] srl_q;
  logic         srl_ce;
  logic [3:0]   srl_adr;
  logic [W-1:0] srl_d;
  logic [W-1:0] q_out;
  logic         q_valid;
  logic         busy;
  logic [3:0]   delay_cur;

  logic         scramble = 1'b1;
  logic         chk_en = 1'b0;
  logic         rnd = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  srl_delay_ctrl #(
    .WIDTH(W),
    .DELAY_INIT(DINIT),
    .FLUSH_LEN(16)
  ) dut (
    .clock(clock),
    .reset(reset),
    .delay_wr(delay_wr),
    .delay_in(delay_in),
    .hold(hold),
    .d_in(d_in),
    .srl_q(srl_q),
    .srl_ce(srl_ce),
    .srl_adr(srl_adr),
    .srl_d(srl_d),
    .q_out(q_out),
    .q_valid(q_valid),
    .busy(busy),
    .delay_cur(delay_cur)
  );

  // behavioural SRL16E bank; scramble preloads garbage the flush must clear
  logic [W-1:0] mem [16];
  always @(posedge clock) begin
    if (scramble) begin
      for (int i = 0; i < 16; i++) mem[i] <= W'($urandom);
    end else if (srl_ce) begin
      mem[0] <= srl_d;
      for (int i = 1; i < 16; i++) mem[i] <= mem[i-1];
    end
  end
  assign srl_q = mem[srl_adr];

  // reference model
  int           n = 0;
  logic [3:0]   madr = DINIT;
  logic [W-1:0] hist[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    logic [W-1:0] esd;
    logic         ev;
    logic [W-1:0] eq;
    @(negedge clock);
    esd = (n >= 16) ? d_in : '0;
    ev  = !hold && (n >= 17 + int'(madr));
    eq  = '0;
    if (ev && hist.size() > int'(madr)) eq = hist[madr];
    if (chk_en) begin
      chk("srl_ce", 32'(srl_ce), 32'(!hold));
      chk("srl_adr", 32'(srl_adr), 32'(madr));
      chk("delay_cur", 32'(delay_cur), 32'(madr));
      chk("srl_d", 32'(srl_d), 32'(esd));
      chk("q_valid", 32'(q_valid), 32'(ev));
      chk("busy", 32'(busy), 32'(!(n >= 17 + int'(madr))));
      chk("q_out", 32'(q_out), 32'(eq));
    end
    @(posedge clock);
    if (!hold) begin
      hist.push_front(esd);
      if (hist.size() > 16) void'(hist.pop_back());
    end
    if (reset) begin
      n = 0;
      madr = DINIT;
    end else if (delay_wr) begin
      n = 0;
      madr = delay_in;
    end else if (!hold && n < 1000) begin
      n++;
    end
    #1;
    if (rnd) d_in = W'($urandom);
    else d_in = d_in + 1'b1;
  endtask

  task automatic wait_valid(input string nm, input int exp,
                            input int hold_at, input int hold_len);
    int c;
    c = 0;
    while (c < 200) begin
      hold = (c >= hold_at) && (c < hold_at + hold_len);
      #1;
      if (q_valid) break;
      cyc();
      c++;
    end
    hold = 1'b0;
    chk(nm, 32'(c), 32'(exp));
  endtask

  typedef struct {
    logic [3:0] adr;
    int         hold_at;
    int         hold_len;
    int         lat;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{adr: 4'd0,  hold_at: 0,  hold_len: 0, lat: 17};
    vecs[1] = '{adr: 4'd3,  hold_at: 0,  hold_len: 0, lat: 20};
    vecs[2] = '{adr: 4'd7,  hold_at: 19, hold_len: 5, lat: 29};
    vecs[3] = '{adr: 4'd15, hold_at: 0,  hold_len: 0, lat: 32};
    vecs[4] = '{adr: 4'd7,  hold_at: 3,  hold_len: 2, lat: 26};
    vecs[5] = '{adr: 4'd12, hold_at: 0,  hold_len: 0, lat: 29};

    // reset with garbage in the shifter
    repeat (3) cyc();
    scramble = 1'b0;
    cyc();
    reset = 1'b0;
    chk_en = 1'b1;
    #1;
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_adr", 32'(srl_adr), 32'(DINIT));
    chk("rst_qout", 32'(q_out), 32'd0);
    wait_valid("reset_fill_lat", 20, 0, 0);
    repeat (10) cyc();

    // table: delay change, optional hold pulse, time to valid
    foreach (vecs[i]) begin
      delay_wr = 1'b1;
      delay_in = vecs[i].adr;
      cyc();
      delay_wr = 1'b0;
      #1;
      chk("wr_drop_valid", 32'(q_valid), 32'd0);
      chk("wr_adr", 32'(delay_cur), 32'(vecs[i].adr));
      wait_valid($sformatf("lat_row%0d", i), vecs[i].lat,
                 vecs[i].hold_at, vecs[i].hold_len);
      repeat (20) cyc();
    end

    // delay write at flush_cnt 9 restarts the flush
    delay_wr = 1'b1;
    delay_in = 4'd5;
    cyc();
    delay_wr = 1'b0;
    repeat (9) cyc();
    delay_wr = 1'b1;
    delay_in = 4'd2;
    cyc();
    delay_wr = 1'b0;
    wait_valid("flush_restart_lat", 19, 0, 0);
    repeat (8) cyc();

    // reset beats delay_wr
    reset = 1'b1;
    delay_wr = 1'b1;
    delay_in = 4'd9;
    cyc();
    reset = 1'b0;
    delay_wr = 1'b0;
    #1;
    chk("rst_wr_valid", 32'(q_valid), 32'd0);
    chk("rst_wr_adr", 32'(delay_cur), 32'(DINIT));
    chk("rst_wr_busy", 32'(busy), 32'd1);
    wait_valid("rst_wr_lat", 20, 0, 0);
    repeat (5) cyc();

    // adr=0, then hold and delay_wr together
    delay_wr = 1'b1;
    delay_in = 4'd0;
    cyc();
    delay_wr = 1'b0;
    wait_valid("adr0_lat", 17, 0, 0);
    repeat (5) cyc();
    hold = 1'b1;
    delay_wr = 1'b1;
    delay_in = 4'd6;
    cyc();
    delay_wr = 1'b0;
    repeat (3) cyc();
    chk("hold_wr_adr", 32'(delay_cur), 32'd6);
    chk("hold_wr_busy", 32'(busy), 32'd1);
    chk("hold_wr_ce", 32'(srl_ce), 32'd0);
    wait_valid("hold_wr_lat", 23, 0, 0);
    repeat (5) cyc();

    // randomized traffic against the model
    rnd = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      hold     = ($urandom_range(0, 5) == 0);
      delay_wr = ($urandom_range(0, 99) == 0);
      reset    = ($urandom_range(0, 499) == 0);
      delay_in = 4'($urandom);
      cyc();
    end
    reset = 1'b0;
    delay_wr = 1'b0;
    hold = 1'b0;
    repeat (40) cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
